grf_wr_arbiter: RTL and testbench
=================================

# grf_wr_arbiter

Write-port arbiter for the 32×32 general register file. Shares the GRF's single write port between the pipeline writeback stage, which can never stall, and a long-latency unit such as mult/div, which uses a valid/ready handshake. Sits between those producers and the GRF's `we3`/`a3`/`wd3`/`pc` inputs. Also reports which read addresses still have a write in flight so that decode can stall.

## Interface
Parameters:
- `DEPTH`, default 2: entries in the long-latency write buffer (≥1).
- `STARVE_LIMIT`, default 4: cycles the buffer head may wait before `stall_req` asserts.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wb_valid`  in  1  pipeline writeback request; always accepted.
- `wb_addr`  in  5  destination register.
- `wb_data`  in  32  write data.
- `wb_pc`  in  32  PC of the writing instruction.
- `md_valid`  in  1  long-latency request valid.
- `md_ready`  out  1  buffer can accept a long-latency request.
- `md_addr`  in  5  destination register.
- `md_data`  in  32  write data.
- `md_pc`  in  32  PC of the writing instruction.
- `grf_we`  out  1  to GRF `we3`.
- `grf_a3`  out  5  to GRF `a3`.
- `grf_wd`  out  32  to GRF `wd3`.
- `grf_pc`  out  32  to GRF `pc`.
- `rd_a1`  in  5  GRF read address 1, from decode.
- `rd_a2`  in  5  GRF read address 2, from decode.
- `pend1`  out  1  a write to `rd_a1` is in flight.
- `pend2`  out  1  a write to `rd_a2` is in flight.
- `stall_req`  out  1  request a one-slot writeback bubble.

## Operation
- The md handshake completes when `md_valid && md_ready`. The request is pushed to the FIFO tail.
- `md_ready = !full`. It depends on registered state only. A full buffer never accepts a request, even when an entry pops in the same cycle.
- Arbitration runs each cycle. `wb_valid` has fixed top priority: the wb request is loaded into the output stage. Otherwise, if the buffer is non-empty, the buffer head is popped into the output stage. Otherwise the output stage loads `grf_we=0`.
- The output stage is registered. `grf_a3`, `grf_wd` and `grf_pc` hold their last values when `grf_we=0`.
- Address 0 requests are forwarded unchanged. The GRF discards them.
- Starvation guard:
  - An age counter increments each cycle the buffer is non-empty and the head is not popped.
  - The counter clears on every pop and whenever the buffer is empty.
  - `stall_req` is registered and equals `age >= STARVE_LIMIT`.
  - `wb_valid` still wins while `stall_req=1`. The pipeline inserts the bubble.
- Pending:
  - `pend1` is 1 when `rd_a1 != 0` and `rd_a1` matches the address of any valid FIFO entry or of the output stage while `grf_we=1`.
  - `pend2` follows the same rule for `rd_a2`.
  - Both are combinational from `rd_a1`/`rd_a2` and registered state.
- Ordering contract: upstream never issues `wb_valid` or `md_valid` to a register with pend set. This block does no reordering checks.

## Timing
- Values after `reset` is asserted: `grf_we=0`, `grf_a3=0`, `grf_wd=0`, `grf_pc=0`, FIFO empty, age counter 0, `stall_req=0`, `md_ready=1`, `pend1=0`, `pend2=0`. The reset takes effect immediately and asynchronously, and any buffered writes are lost.
- wb latency: request in cycle N appears on `grf_*` in cycle N+1, with the GRF write at the end of N+1.
- md latency: accept in cycle N, then at best pop in N+1 and `grf_we` in N+2. There is no bypass around the FIFO.
- FIFO pointers wrap modulo `DEPTH`. A simultaneous push and pop keeps the occupancy unchanged.
- `stall_req` asserts in the cycle after age reaches `STARVE_LIMIT`. It deasserts in the cycle after the pop.

## Structure
- Package `grf_pkg`:
  - `REG_AW=5`, `DATA_W=32`.
  - typedef `grf_wr_t` with fields {addr, data, pc}, used for the FIFO entries and the output stage.
- Sub-module `grf_wr_fifo` contains:
  - a `DEPTH`-entry circular buffer of `grf_wr_t`;
  - full/empty flags;
  - a per-entry valid/address vector exported for the pend comparators.
- The top level contains the arbiter, output register, age counter and pend logic.

## Test plan
- **Reset:** hold `reset=0` with all inputs active → all outputs at reset values, `md_ready=1`. Release → first wb request {addr=5, data=0x1234, pc=0x3000} appears on `grf_*` with `grf_we=1` one cycle later.
- **Priority:** `wb_valid` and `md_valid` in the same cycle, targeting $3 and $7 → $3 is issued at N+1, $7 at N+2, `md_ready` stays 1.
- **Full buffer:** `DEPTH=2`, three consecutive md requests while `wb_valid` is held high → `md_ready=0` after two accepts and the third is held. Dropping `wb_valid` drains the entries in FIFO order.
- **Starvation:** one buffered md write, `wb_valid` held high → `stall_req=1` after 4 blocked cycles. A one-cycle `wb_valid=0` pops the entry and `stall_req` clears next cycle.
- **Pending:** buffered write to $9, `rd_a1=9`, `rd_a2=0` → `pend1=1`, `pend2=0`. `pend1` stays 1 through the output-stage cycle and is 0 after the GRF write.
- **Async reset:** assert `reset` mid-drain with 2 entries buffered → `grf_we=0` immediately and no stale write appears after release.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared widths and the write-request record used by the GRF write-port arbiter.
package grf_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } grf_wr_t;

endpackage

// File: rtl/grf_wr_arbiter_if.sv
// Bus bundle between the writeback/long-latency producers, decode and the GRF write port.
interface grf_wr_arbiter_if;
  import grf_pkg::*;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] wb_pc;

  // md_valid/md_ready: a request transfers on a rising edge where both are high; once
  // raised, md_valid and its payload stay stable until that edge. md_ready is registered-only.
  logic              md_valid;
  logic              md_ready;
  logic [REG_AW-1:0] md_addr;
  logic [DATA_W-1:0] md_data;
  logic [DATA_W-1:0] md_pc;

  logic              grf_we;
  logic [REG_AW-1:0] grf_a3;
  logic [DATA_W-1:0] grf_wd;
  logic [DATA_W-1:0] grf_pc;

  logic [REG_AW-1:0] rd_a1;
  logic [REG_AW-1:0] rd_a2;
  logic              pend1;
  logic              pend2;
  logic              stall_req;

  modport master (
    output wb_valid, wb_addr, wb_data, wb_pc,
    output md_valid, md_addr, md_data, md_pc,
    output rd_a1, rd_a2,
    input  md_ready, grf_we, grf_a3, grf_wd, grf_pc,
    input  pend1, pend2, stall_req
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, wb_pc,
    input  md_valid, md_addr, md_data, md_pc,
    input  rd_a1, rd_a2,
    output md_ready, grf_we, grf_a3, grf_wd, grf_pc,
    output pend1, pend2, stall_req
  );

endinterface

// File: rtl/grf_wr_fifo.sv
// Circular buffer of pending long-latency GRF writes; exposes per-entry valid/address for hazard checks.
module grf_wr_fifo
  import grf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  grf_wr_t                      push_entry,
  input  logic                         pop,
  output grf_wr_t                      head,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0] entry_addr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  grf_wr_t          mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] valid_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A per-slot valid bit doubles as the occupancy record: push and pop never
  // touch the same slot in one cycle because pop needs an entry and push needs a hole.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_comb begin
    entry_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = mem[i].addr;
    end
  end

  assign head        = mem[rd_ptr];
  assign full        = &valid_q;
  assign empty       = ~|valid_q;
  assign entry_valid = valid_q;

endmodule

// File: rtl/grf_wr_arbiter.sv
// Shares the GRF write port between never-stalling writeback and buffered long-latency writes.
module grf_wr_arbiter
  import grf_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  grf_wr_arbiter_if.slave   bus
);

  localparam int AGE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  grf_wr_t                      wb_entry;
  grf_wr_t                      md_entry;
  grf_wr_t                      head;
  grf_wr_t                      out_q;
  logic                         we_q;
  logic                         full;
  logic                         empty;
  logic                         push;
  logic                         pop;
  logic [DEPTH-1:0]             entry_valid;
  logic [DEPTH-1:0][REG_AW-1:0] entry_addr;
  logic [AGE_W-1:0]             age_q;
  logic [AGE_W-1:0]             age_d;
  logic                         stall_q;
  logic                         hit1;
  logic                         hit2;

  assign wb_entry = '{addr: bus.wb_addr, data: bus.wb_data, pc: bus.wb_pc};
  assign md_entry = '{addr: bus.md_addr, data: bus.md_data, pc: bus.md_pc};

  // Ready comes from registered fullness only, so a pop cannot open a slot for a same-cycle push.
  assign push = bus.md_valid && !full;
  assign pop  = !bus.wb_valid && !empty;

  grf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (md_entry),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      we_q  <= 1'b0;
    end else if (bus.wb_valid) begin
      out_q <= wb_entry;
      we_q  <= 1'b1;
    end else if (pop) begin
      out_q <= head;
      we_q  <= 1'b1;
    end else begin
      we_q  <= 1'b0;
    end
  end

  // Age saturates at the limit; stall_req tracks the new age so it drops right after a pop.
  always_comb begin
    age_d = '0;
    if (!empty && !pop) begin
      age_d = (age_q < AGE_W'(STARVE_LIMIT)) ? age_q + AGE_W'(1) : age_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      stall_q <= (age_d >= AGE_W'(STARVE_LIMIT));
    end
  end

  always_comb begin
    hit1 = we_q && (out_q.addr == bus.rd_a1);
    hit2 = we_q && (out_q.addr == bus.rd_a2);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == bus.rd_a1)) hit1 = 1'b1;
      if (entry_valid[i] && (entry_addr[i] == bus.rd_a2)) hit2 = 1'b1;
    end
  end

  assign bus.pend1     = hit1 && (bus.rd_a1 != '0);
  assign bus.pend2     = hit2 && (bus.rd_a2 != '0);
  assign bus.md_ready  = !full;
  assign bus.grf_we    = we_q;
  assign bus.grf_a3    = out_q.addr;
  assign bus.grf_wd    = out_q.data;
  assign bus.grf_pc    = out_q.pc;
  assign bus.stall_req = stall_q;

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Directed plus randomized bench for grf_wr_arbiter against a queue-based reference model.
module tb_grf_wr_arbiter;
  import grf_pkg::*;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int W            = REG_AW + 2 * DATA_W;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wr_arbiter_if bus ();

  grf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: buffered writes in order, output stage, cycles the head has waited
  grf_wr_t    m_q[$];
  grf_wr_t    m_out;
  bit         m_we;
  int         m_age;
  logic [W-1:0] exp_q[$];
  grf_wr_t    md_todo[$];
  bit         md_acc;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic grf_wr_t mk(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    grf_wr_t e;
    e.addr = a;
    e.data = d;
    e.pc   = p;
    return e;
  endfunction

  function automatic bit m_pend(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (m_q[i]) if (m_q[i].addr == a) return 1'b1;
    return m_we && (m_out.addr == a);
  endfunction

  function automatic logic [4:0] pick_free();
    logic [4:0] a;
    for (int k = 0; k < 64; k++) begin
      a = 5'($urandom_range(0, 31));
      if (!m_pend(a)) return a;
    end
    return 5'd0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_out = '0;
    m_we  = 1'b0;
    m_age = 0;
    exp_q.delete();
    md_todo.delete();
  endtask

  task automatic model_edge(input bit wbv, input grf_wr_t wb, input bit mdv, input grf_wr_t md);
    bit had;
    bit popped;
    had    = (m_q.size() > 0);
    popped = 1'b0;
    md_acc = mdv && (m_q.size() < DEPTH);
    if (wbv) begin
      m_out = wb;
      m_we  = 1'b1;
    end else if (had) begin
      m_out  = m_q.pop_front();
      m_we   = 1'b1;
      popped = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (m_we) exp_q.push_back(m_out);
    if (md_acc) m_q.push_back(md);
    m_age = (had && !popped) ? m_age + 1 : 0;
  endtask

  task automatic check_outputs();
    check("md_ready",  W'(bus.md_ready),  W'(m_q.size() < DEPTH));
    check("grf_we",    W'(bus.grf_we),    W'(m_we));
    check("grf_a3",    W'(bus.grf_a3),    W'(m_out.addr));
    check("grf_wd",    W'(bus.grf_wd),    W'(m_out.data));
    check("grf_pc",    W'(bus.grf_pc),    W'(m_out.pc));
    check("stall_req", W'(bus.stall_req), W'(m_age >= STARVE_LIMIT));
    check("pend1",     W'(bus.pend1),     W'(m_pend(bus.rd_a1)));
    check("pend2",     W'(bus.pend2),     W'(m_pend(bus.rd_a2)));
    if (bus.grf_we === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_write", W'(bus.grf_we), W'(1'b0));
      else check("write_order", {bus.grf_a3, bus.grf_wd, bus.grf_pc}, exp_q.pop_front());
    end
  endtask

  // driver: one clock cycle; entered and left 1 time unit after a rising edge
  task automatic step(input bit wbv, input grf_wr_t wb, input logic [4:0] r1, input logic [4:0] r2);
    grf_wr_t md;
    bus.wb_valid = wbv;
    bus.wb_addr  = wb.addr;
    bus.wb_data  = wb.data;
    bus.wb_pc    = wb.pc;
    if (md_todo.size() > 0) begin
      md = md_todo[0];
      bus.md_valid = 1'b1;
      bus.md_addr  = md.addr;
      bus.md_data  = md.data;
      bus.md_pc    = md.pc;
    end else begin
      md = '0;
      bus.md_valid = 1'b0;
    end
    bus.rd_a1 = r1;
    bus.rd_a2 = r2;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(wbv, wb, bus.md_valid, md);
    if (md_acc) void'(md_todo.pop_front());
    #1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, mk(5'd0, $urandom(), $urandom()), r1, r2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         wbv;
    logic [4:0] r1;
    logic [4:0] r2;

    // reset held with every input active
    reset        = 1'b0;
    model_reset();
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd5;
    bus.wb_data  = 32'hdead;
    bus.wb_pc    = 32'h100;
    bus.md_valid = 1'b1;
    bus.md_addr  = 5'd7;
    bus.md_data  = 32'hbeef;
    bus.md_pc    = 32'h104;
    bus.rd_a1    = 5'd5;
    bus.rd_a2    = 5'd7;
    repeat (2) @(posedge clk);
    #2;
    check("rst_grf_we",    W'(bus.grf_we),    W'(0));
    check("rst_grf_a3",    W'(bus.grf_a3),    W'(0));
    check("rst_grf_wd",    W'(bus.grf_wd),    W'(0));
    check("rst_grf_pc",    W'(bus.grf_pc),    W'(0));
    check("rst_md_ready",  W'(bus.md_ready),  W'(1));
    check("rst_stall_req", W'(bus.stall_req), W'(0));
    check("rst_pend1",     W'(bus.pend1),     W'(0));
    check("rst_pend2",     W'(bus.pend2),     W'(0));
    reset = 1'b1;

    step(1'b1, mk(5'd5, 32'h1234, 32'h3000), 5'd0, 5'd0);
    check("first_we", W'(bus.grf_we), W'(1));
    check("first_a3", W'(bus.grf_a3), W'(5));
    check("first_wd", W'(bus.grf_wd), W'(32'h1234));
    check("first_pc", W'(bus.grf_pc), W'(32'h3000));

    // priority: wb $3 and md $7 together
    md_todo.push_back(mk(5'd7, 32'h7777, 32'h3004));
    step(1'b1, mk(5'd3, 32'h3333, 32'h3008), 5'd0, 5'd0);
    check("prio_first_a3", W'(bus.grf_a3),   W'(3));
    check("prio_ready",    W'(bus.md_ready), W'(1));
    idle(5'd0, 5'd0);
    check("prio_second_a3", W'(bus.grf_a3), W'(7));
    check("prio_second_we", W'(bus.grf_we), W'(1));
    idle(5'd0, 5'd0);

    // full buffer under continuous writeback
    md_todo.push_back(mk(5'd10, 32'ha0, 32'h4000));
    md_todo.push_back(mk(5'd11, 32'ha1, 32'h4004));
    md_todo.push_back(mk(5'd12, 32'ha2, 32'h4008));
    for (int k = 0; k < 4; k++) begin
      step(1'b1, mk(5'(16 + k), $urandom(), $urandom()), 5'd0, 5'd0);
      if (k >= 1) check("full_not_ready", W'(bus.md_ready), W'(0));
    end
    idle(5'd0, 5'd0);
    check("drain_a3_0", W'(bus.grf_a3), W'(10));
    idle(5'd0, 5'd0);
    check("drain_a3_1", W'(bus.grf_a3), W'(11));
    idle(5'd0, 5'd0);
    check("drain_a3_2", W'(bus.grf_a3), W'(12));
    repeat (2) idle(5'd0, 5'd0);

    // starvation
    md_todo.push_back(mk(5'd13, 32'hc0de, 32'h5000));
    step(1'b1, mk(5'd24, $urandom(), $urandom()), 5'd0, 5'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, mk(5'(24 + k), $urandom(), $urandom()), 5'd0, 5'd0);
      if (k == 3) check("starve_not_yet", W'(bus.stall_req), W'(0));
      if (k == 4) check("starve_stall",   W'(bus.stall_req), W'(1));
    end
    idle(5'd0, 5'd0);
    check("starve_clear", W'(bus.stall_req), W'(0));
    check("starve_pop",   W'(bus.grf_a3),    W'(13));
    idle(5'd0, 5'd0);

    // pending through buffer and output stage
    md_todo.push_back(mk(5'd9, 32'h9999, 32'h6000));
    idle(5'd9, 5'd0);
    check("pend_buf_1", W'(bus.pend1), W'(1));
    check("pend_buf_2", W'(bus.pend2), W'(0));
    idle(5'd9, 5'd0);
    check("pend_out_1", W'(bus.pend1), W'(1));
    idle(5'd9, 5'd0);
    check("pend_done_1", W'(bus.pend1), W'(0));

    // asynchronous reset mid-drain
    md_todo.push_back(mk(5'd20, 32'h2020, 32'h7000));
    md_todo.push_back(mk(5'd21, 32'h2121, 32'h7004));
    step(1'b1, mk(5'd29, $urandom(), $urandom()), 5'd0, 5'd0);
    step(1'b1, mk(5'd30, $urandom(), $urandom()), 5'd0, 5'd0);
    idle(5'd21, 5'd20);
    check("mid_drain_a3", W'(bus.grf_a3), W'(20));
    #3;
    reset = 1'b0;
    #1;
    check("arst_we",    W'(bus.grf_we),   W'(0));
    check("arst_ready", W'(bus.md_ready), W'(1));
    check("arst_pend1", W'(bus.pend1),    W'(0));
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (3) idle(5'd21, 5'd20);
    check("arst_no_stale", W'(bus.grf_we), W'(0));

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      wbv = ($urandom_range(0, 99) < ((c < 200) ? 50 : 85));
      if (md_todo.size() == 0 && $urandom_range(0, 2) == 0)
        md_todo.push_back(mk(pick_free(), $urandom(), $urandom()));
      r1 = (m_q.size() > 0 && $urandom_range(0, 1) == 1) ? m_q[0].addr : 5'($urandom_range(0, 31));
      r2 = m_we ? m_out.addr : 5'($urandom_range(0, 31));
      step(wbv, mk(pick_free(), $urandom(), $urandom()), r1, r2);
    end
    repeat (8) idle(5'd0, 5'd0);
    check("final_drained", W'(exp_q.size()), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
